// File: rtl/aes_pkg.sv
// Shared definitions for the AES inverse cipher: inverse S-box, GF(2^8)
// multipliers, the InvMixColumns column transform and the FSM state type.
package aes_pkg;

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

  function automatic bit nr_legal(input int nr);
    return (nr == 10) || (nr == 12) || (nr == 14);
  endfunction

  // Entry 0x00 sits in the most significant byte, entry 0xff in the least.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] msb;
    msb = 11'd2047 - {b, 3'b000};
    return INV_SBOX[msb -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Column is {row0, row1, row2, row3} from MSB to LSB.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul09(a3),
            gf_mul09(a0) ^ gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3),
            gf_mul0d(a0) ^ gf_mul09(a1) ^ gf_mul0e(a2) ^ gf_mul0b(a3),
            gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul09(a2) ^ gf_mul0e(a3)};
  endfunction

endpackage

// File: rtl/inv_shift_rows.sv
// InvShiftRows: row r of the column-major state rotates right by r columns,
// undoing the forward cipher's row shift.
module inv_shift_rows (
  input  logic [127:0] block,
  output logic [127:0] shifted
);

  // Byte (r,c) lives at bits [127-8*(4c+r) -: 8].
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[127-8*(4*c+r) -: 8] = block[127-8*(4*((c+4-r)%4)+r) -: 8];
    end
  end

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES inverse cipher: one decryption round per clock, with round
// keys fetched by index from an external key-schedule store.
module aes_inv_cipher_core
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] cipherText,
  output logic [3:0]   roundKeyIndex,
  input  logic [127:0] roundKey,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] plainText,
  output logic         busy
);

  if (!nr_legal(NR)) begin : g_bad_nr
    $error("aes_inv_cipher_core: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] LAST_KEY  = 4'(NR);
  localparam logic [3:0] FIRST_CTR = 4'(NR - 1);

  state_t       fsm_state;
  state_t       fsm_next;
  logic [127:0] blk;
  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;
  logic [3:0]   ctr;

  inv_shift_rows u_inv_shift_rows (
    .block   (blk),
    .shifted (shifted)
  );

  // FINAL takes the round result before the column mix; ROUND takes it after.
  always_comb begin
    subbed = '0;
    mixed  = '0;
    for (int i = 0; i < 16; i++) begin
      subbed[8*i +: 8] = inv_sbox(shifted[8*i +: 8]);
    end
    keyed = subbed ^ roundKey;
    for (int c = 0; c < 4; c++) begin
      mixed[32*c +: 32] = inv_mix_column(keyed[32*c +: 32]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_state <= IDLE;
    end else begin
      fsm_state <= fsm_next;
    end
  end

  always_comb begin
    fsm_next = fsm_state;
    case (fsm_state)
      IDLE:    if (inValid) fsm_next = INIT;
      INIT:    fsm_next = ROUND;
      ROUND:   if (ctr == 4'd1) fsm_next = FINAL;
      FINAL:   fsm_next = DONE;
      DONE:    if (outReady) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk <= '0;
      ctr <= FIRST_CTR;
    end else begin
      case (fsm_state)
        IDLE:  if (inValid) blk <= cipherText;
        INIT: begin
          blk <= blk ^ roundKey;
          ctr <= FIRST_CTR;
        end
        ROUND: begin
          blk <= mixed;
          ctr <= ctr - 4'd1;
        end
        FINAL: blk <= keyed;
        default: ;
      endcase
    end
  end

  // The last-round key index doubles as the idle value so the key store
  // address stays deterministic outside a decryption.
  always_comb begin
    inReady       = 1'b0;
    busy          = 1'b1;
    outValid      = 1'b0;
    plainText     = '0;
    roundKeyIndex = LAST_KEY;
    case (fsm_state)
      IDLE: begin
        inReady = 1'b1;
        busy    = 1'b0;
      end
      INIT:  roundKeyIndex = LAST_KEY;
      ROUND: roundKeyIndex = ctr;
      FINAL: roundKeyIndex = 4'd0;
      DONE: begin
        outValid  = 1'b1;
        plainText = blk;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Self-checking bench: three cores (NR = 10/12/14) checked every cycle against
// a timing model, with ciphertexts produced by a forward AES model in the bench.
`timescale 1ns/1ps
module tb_aes_inv_cipher_core;

  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid    [NI];
  logic         in_ready    [NI];
  logic [127:0] cipher_text [NI];
  logic [3:0]   rk_idx      [NI];
  logic [127:0] round_key   [NI];
  logic         out_valid   [NI];
  logic         out_ready   [NI];
  logic [127:0] plain_text  [NI];
  logic         busy        [NI];

  logic [127:0] rk_mem [NI][16];
  logic [127:0] pt_in  [NI];
  logic [7:0]   sbox_t [256];
  logic [127:0] fips_ct [NI] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                                 128'h8ea2b7ca516745bfeafc49904b496089};
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  bit     checking = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand_key(input int k, input logic [255:0] key);
    int          nr, nk;
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    nr   = 10 + 2*k;
    nk   = nr - 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]});
        tmp[31:24] = tmp[31:24] ^ rcon;
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r <= nr; r++) rk_mem[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(int k, logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    int           nr;
    nr = 10 + 2*k;
    t  = '0;
    s  = pt ^ rk_mem[k][0];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          t[127-8*(4*c+r) -: 8] = sbox_t[s[127-8*(4*((c+r)%4)+r) -: 8]];
        end
      end
      if (rnd < nr) begin
        s = t;
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8];
          a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8];
          a3 = s[103-32*c -: 8];
          t[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                               a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                               a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                               gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
        end
      end
      s = t ^ rk_mem[k][rnd];
    end
    return s;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GNR = 10 + 2*g;

    assign round_key[g] = rk_mem[g][rk_idx[g]];

    aes_inv_cipher_core #(.NR(GNR)) dut (
      .clk           (clk),
      .reset         (reset),
      .inValid       (in_valid[g]),
      .inReady       (in_ready[g]),
      .cipherText    (cipher_text[g]),
      .roundKeyIndex (rk_idx[g]),
      .roundKey      (round_key[g]),
      .outValid      (out_valid[g]),
      .outReady      (out_ready[g]),
      .plainText     (plain_text[g]),
      .busy          (busy[g])
    );

    // Model: a block is in flight for NR+1 cycles after acceptance, then
    // offered until taken; key index counts down from NR to 0 meanwhile.
    bit           active      = 1'b0;
    int           phase       = 0;
    logic [127:0] exp_pt      = '0;
    bit           after_reset = 1'b0;

    always @(negedge clk) begin
      logic       exp_valid;
      logic [3:0] exp_idx;
      if (checking) begin
        exp_valid = active && (phase == GNR + 1);
        exp_idx   = (active && phase <= GNR) ? 4'(GNR - phase) : 4'(GNR);
        n_checks++;
        if (out_valid[g] !== exp_valid || in_ready[g] !== !active || busy[g] !== active ||
            rk_idx[g] !== exp_idx || (exp_valid && plain_text[g] !== exp_pt) ||
            (after_reset && plain_text[g] !== 128'h0)) begin
          n_fail++;
          $display("[TB] FAIL model nr%0d cycle %0d: got valid=%b ready=%b busy=%b idx=%0d pt=%h, want valid=%b ready=%b busy=%b idx=%0d pt=%h",
                   GNR, cyc, out_valid[g], in_ready[g], busy[g], rk_idx[g], plain_text[g],
                   exp_valid, !active, active, exp_idx, after_reset ? 128'h0 : exp_pt);
        end
      end
      after_reset = 1'b0;
      if (reset) begin
        active      = 1'b0;
        after_reset = 1'b1;
      end else if (!active) begin
        if (in_valid[g]) begin
          active = 1'b1;
          phase  = 0;
          exp_pt = pt_in[g];
        end
      end else if (phase < GNR + 1) begin
        phase++;
      end else if (out_ready[g]) begin
        active = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int k, input logic [127:0] pt, output longint acc_cyc);
    int tries;
    bit taken;
    tries = 0;
    taken = 1'b0;
    @(posedge clk);
    #1;
    cipher_text[k] = encrypt(k, pt);
    pt_in[k]       = pt;
    in_valid[k]    = 1'b1;
    while (!taken && tries < 200) begin
      @(negedge clk);
      taken = in_ready[k];
      tries++;
      @(posedge clk);
      #1;
    end
    acc_cyc = cyc;
    if (!taken) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept timeout nr%0d", 10 + 2*k);
    end
  endtask

  task automatic waitOutput(input int k, input longint acc, input logic [127:0] exp);
    int tries;
    tries = 0;
    do begin
      @(negedge clk);
      tries++;
    end while (!out_valid[k] && tries < 100);
    checkOutput($sformatf("latency nr%0d", 10 + 2*k), 128'(cyc - acc), 128'(11 + 2*k));
    checkOutput($sformatf("plainText nr%0d", 10 + 2*k), plain_text[k], exp);
  endtask

  task automatic waitIdle(input int k);
    int tries;
    tries = 0;
    do begin
      @(negedge clk);
      tries++;
    end while (!in_ready[k] && tries < 100);
    checkOutput($sformatf("return to idle nr%0d", 10 + 2*k), 128'(in_ready[k]), 128'(1));
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: bench did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint       acc [3];
    logic [255:0] key;
    logic [127:0] pts [3];
    int           tries;

    build_sbox();
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      in_valid[k]    = 1'b0;
      out_ready[k]   = 1'b1;
      cipher_text[k] = '0;
      pt_in[k]       = '0;
      for (int r = 0; r < 16; r++) rk_mem[k][r] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    checking = 1'b1;

    for (int k = 0; k < NI; k++) begin
      checkOutput($sformatf("reset ready/busy/valid nr%0d", 10 + 2*k),
                  128'({in_ready[k], busy[k], out_valid[k]}), 128'(3'b100));
      checkOutput($sformatf("reset key index nr%0d", 10 + 2*k), 128'(rk_idx[k]), 128'(10 + 2*k));
      checkOutput($sformatf("reset plainText nr%0d", 10 + 2*k), plain_text[k], 128'h0);
    end

    // FIPS-197 appendix C vectors: key bytes 00,01,02,... for every key size.
    key = '0;
    for (int i = 0; i < 32; i++) key[255-8*i -: 8] = 8'(i);
    for (int k = 0; k < NI; k++) begin
      expand_key(k, key);
      checkOutput($sformatf("reference encrypt nr%0d", 10 + 2*k), encrypt(k, FIPS_PT), fips_ct[k]);
      applyStimulus(k, FIPS_PT, acc[0]);
      in_valid[k] = 1'b0;
      waitOutput(k, acc[0], 128'h00112233445566778899aabbccddeeff);
      waitIdle(k);
    end

    // Backpressure with a competing request held high throughout.
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    pts[0] = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(0, pts[0], acc[0]);
    cipher_text[0] = {$urandom, $urandom, $urandom, $urandom};
    waitOutput(0, acc[0], pts[0]);
    repeat (20) @(negedge clk);
    checkOutput("backpressure plainText", plain_text[0], pts[0]);
    checkOutput("backpressure ready/valid", 128'({in_ready[0], out_valid[0]}), 128'(2'b01));
    @(posedge clk);
    #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    waitIdle(0);

    // Abort in the fifth ROUND cycle, then decrypt C.1 again.
    applyStimulus(0, FIPS_PT, acc[0]);
    in_valid[0] = 1'b0;
    tries = 0;
    do begin
      @(posedge clk);
      #1;
      tries++;
    end while (rk_idx[0] != 4'd5 && tries < 50);
    checkOutput("abort point key index", 128'(rk_idx[0]), 128'(5));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort ready/busy/valid", 128'({in_ready[0], busy[0], out_valid[0]}), 128'(3'b100));
    applyStimulus(0, FIPS_PT, acc[0]);
    in_valid[0] = 1'b0;
    waitOutput(0, acc[0], FIPS_PT);
    waitIdle(0);

    // Back-to-back random blocks under random keys.
    for (int k = 0; k < NI; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      expand_key(k, key);
      for (int j = 0; j < 3; j++) begin
        pts[j] = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(k, pts[j], acc[j]);
      end
      in_valid[k] = 1'b0;
      checkOutput($sformatf("accept spacing 1 nr%0d", 10 + 2*k), 128'(acc[1] - acc[0]), 128'(13 + 2*k));
      checkOutput($sformatf("accept spacing 2 nr%0d", 10 + 2*k), 128'(acc[2] - acc[1]), 128'(13 + 2*k));
      waitIdle(k);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
